// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches source raise edges, hands one request at a time to
// the CPU and routes its acknowledge back. Define IRQ_CTRL_COUNT_EN for per-source service counters.
module irq_controller #(
    parameter int unsigned NUM_SOURCES     = 4,
    parameter logic [7:0]  IrqCtrlBaseAddr = 8'hE0,
    parameter logic [7:0]  InitialEnable   = 8'hFF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    inout  wire  [7:0]             BUS_DATA,
    input  logic [7:0]             BUS_ADDR,
    input  logic                   BUS_WE,
    input  logic [NUM_SOURCES-1:0] SRC_INTERRUPT_RAISE,
    output logic [NUM_SOURCES-1:0] SRC_INTERRUPT_ACK,
    output logic                   CPU_INTERRUPT_RAISE,
    output logic [2:0]             CPU_INTERRUPT_ID,
    input  logic                   CPU_INTERRUPT_ACK
);

    typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

    state_e                 state_q;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] enable_q;
    logic [NUM_SOURCES-1:0] hist_q;
    logic [NUM_SOURCES-1:0] capture;
    logic [NUM_SOURCES-1:0] sw_clear;
    logic [NUM_SOURCES-1:0] ack_vec;
    logic [NUM_SOURCES-1:0] src_ack_q;
    logic [2:0]             cur_id_q;
    logic [2:0]             cand_id;
    logic                   cand_valid;
    logic                   ack_fire;
    logic                   cpu_raise_q;
    logic [7:0]             offset;
    logic [7:0]             wr_data;
    logic [7:0]             rd_sel;
    logic [7:0]             rd_data_q;
    logic                   rd_hit;
    logic                   oe_q;
    logic                   unused_wr_data;

    assign offset         = BUS_ADDR - IrqCtrlBaseAddr;
    assign wr_data        = BUS_DATA;
    assign unused_wr_data = ^wr_data;
    assign BUS_DATA       = oe_q ? rd_data_q : 8'bz;

    assign SRC_INTERRUPT_ACK   = src_ack_q;
    assign CPU_INTERRUPT_RAISE = cpu_raise_q;
    assign CPU_INTERRUPT_ID    = cur_id_q;

    assign capture  = SRC_INTERRUPT_RAISE & ~hist_q & enable_q;
    assign sw_clear = (BUS_WE && offset == 8'd3) ? wr_data[NUM_SOURCES-1:0] : '0;
    assign ack_fire = (state_q == StReq) && CPU_INTERRUPT_ACK;

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            ack_vec[i] = ack_fire && (cur_id_q == 3'(i));
        end
    end

    // A fresh capture overrides any clear of the same bit in the same cycle.
    assign pending_d = (pending_q & ~sw_clear & ~ack_vec) | capture;

    // Scan from the top down so the lowest ready index wins.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                cand_valid = 1'b1;
                cand_id    = 3'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            cur_id_q    <= '0;
            cpu_raise_q <= 1'b0;
            src_ack_q   <= '0;
        end else begin
            src_ack_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (cand_valid) begin
                        state_q     <= StReq;
                        cur_id_q    <= cand_id;
                        cpu_raise_q <= 1'b1;
                    end
                end
                StReq: begin
                    // Committed: software clears of this source do not withdraw the request.
                    if (CPU_INTERRUPT_ACK) begin
                        state_q     <= StAck;
                        cpu_raise_q <= 1'b0;
                        src_ack_q   <= ack_vec;
                    end
                end
                StAck: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IRQ_CTRL_COUNT_EN
    logic [7:0] count_q [NUM_SOURCES];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(NUM_SOURCES); i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SOURCES); i++) begin
                if (BUS_WE && offset == 8'(4 + i)) begin
                    count_q[i] <= '0;
                end else if (ack_vec[i]) begin
                    count_q[i] <= count_q[i] + 8'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        case (offset)
            8'd0: begin
                rd_hit = 1'b1;
                rd_sel = 8'(pending_q);
            end
            8'd1: begin
                rd_hit = 1'b1;
                rd_sel = 8'(enable_q);
            end
            8'd2: begin
                rd_hit = 1'b1;
                rd_sel = {5'b0, cur_id_q};
            end
            default: ;
        endcase
`ifdef IRQ_CTRL_COUNT_EN
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (offset == 8'(4 + i)) begin
                rd_hit = 1'b1;
                rd_sel = count_q[i];
            end
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= '0;
            enable_q  <= InitialEnable[NUM_SOURCES-1:0];
            hist_q    <= '0;
            oe_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            pending_q <= pending_d;
            hist_q    <= SRC_INTERRUPT_RAISE;
            if (BUS_WE && offset == 8'd1) begin
                enable_q <= wr_data[NUM_SOURCES-1:0];
            end
            // Bus is driven one cycle after the address phase of a read.
            oe_q      <= !BUS_WE && rd_hit;
            rd_data_q <= rd_sel;
        end
    end

endmodule
